bus_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one `gnt`/`adr` bus among `N` requesters. Each requester raises `req[i]` with its target address on `adr_in[i]`. The block grants exactly one owner at a time, drives the shared `bus_gnt`/`bus_adr` pair that downstream property checks observe (e.g. `bus_gnt && bus_adr == 100`), and bounds each tenure with a hold limit. It sits between the requesting masters and the shared address/grant bus.

---
 rtl/bus_rr_arbiter.sv | 111 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for a shared grant/address bus. Each tenure is capped at
// MAX_HOLD cycles and followed by a GAP cycle before the next arbitration.

module bus_rr_lane #(
    parameter int IDX = 0,
    parameter int OW  = 2
) (
    input  logic [OW-1:0] ptr,
    input  logic          req,
    output logic          hi
);
    // Set when this requester sits at or above the rotating priority pointer
    assign hi = req && (OW'(IDX) >= ptr);
endmodule

module bus_rr_arbiter #(
    parameter int N        = 4,
    parameter int AW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*AW-1:0]      adr_in,
    output logic [N-1:0]         gnt,
    output logic                 bus_gnt,
    output logic [AW-1:0]        bus_adr,
    output logic [$clog2(N)-1:0] owner
);
    localparam int OW = $clog2(N);
    localparam logic [7:0] HLAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t               state, state_d;
    logic [OW-1:0]        ptr, ptr_d, owner_d, win;
    logic [7:0]           hold_cnt, hold_d;
    logic [N-1:0]         gnt_d, hi;
    logic [AW-1:0]        adr_d;
    logic [N-1:0][AW-1:0] adr_v;

    assign adr_v   = adr_in;
    assign bus_gnt = |gnt;

    for (genvar i = 0; i < N; i++) begin : g_lane
        bus_rr_lane #(.IDX(i), .OW(OW)) u_lane (
            .ptr (ptr),
            .req (req[i]),
            .hi  (hi[i])
        );
    end

    // Lowest requester at/above ptr wins; otherwise wrap to the lowest overall
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) win = OW'(i);
        for (int i = N - 1; i >= 0; i--)
            if (hi[i]) win = OW'(i);
    end

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        adr_d   = bus_adr;
        owner_d = owner;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = win;
                    gnt_d   = N'(1) << win;
                    adr_d   = adr_v[win];
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[owner] || hold_cnt == HLAST) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    adr_d   = '0;
                    ptr_d   = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
                end else if (hold_cnt < HLAST) begin
                    hold_d = hold_cnt + 8'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            bus_adr  <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            bus_adr  <= adr_d;
            owner    <= owner_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: one instance with MAX_HOLD=8 and one with
// MAX_HOLD=2 for the round-robin rotation; outputs sampled on the falling edge.

module tb_bus_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req2;
    logic [31:0] adr_in, adr2;
    logic [3:0]  gnt, gnt2;
    logic        bus_gnt, bus_gnt2;
    logic [7:0]  bus_adr, bus_adr2;
    logic [1:0]  owner, owner2;

    int checks = 0;
    int errors = 0;

    int exp_g [5] = '{1, 2, 4, 8, 1};
    int exp_a [5] = '{10, 20, 30, 40, 10};

    bus_rr_arbiter #(.N(4), .AW(8), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .adr_in(adr_in),
        .gnt(gnt), .bus_gnt(bus_gnt), .bus_adr(bus_adr), .owner(owner)
    );

    bus_rr_arbiter #(.N(4), .AW(8), .MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .adr_in(adr2),
        .gnt(gnt2), .bus_gnt(bus_gnt2), .bus_adr(bus_adr2), .owner(owner2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Bus invariants on both instances every cycle
    always @(negedge clk) begin
        chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("inv_busgnt", 32'(bus_gnt), 32'(|gnt));
        chk("inv_adr0", 32'(!bus_gnt && bus_adr != 8'd0), 32'd0);
        chk("inv2_onehot", 32'($onehot0(gnt2)), 32'd1);
        chk("inv2_busgnt", 32'(bus_gnt2), 32'(|gnt2));
        chk("inv2_adr0", 32'(!bus_gnt2 && bus_adr2 != 8'd0), 32'd0);
    end

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        req2   = '0;
        adr_in = '0;
        adr2   = {8'd40, 8'd30, 8'd20, 8'd10};

        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busgnt", bus_gnt, 0);
        chk("rst_adr", bus_adr, 0);
        chk("rst_owner", owner, 0);
        rst_n = 1'b1;

        // single requester, 3-cycle tenure
        req = 4'b0100;
        adr_in[23:16] = 8'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_gnt", gnt, 4'b0100);
            chk("single_adr", bus_adr, 100);
            chk("single_owner", owner, 2);
        end
        req = '0;
        @(negedge clk);
        chk("single_gap_gnt", bus_gnt, 0);
        chk("single_gap_adr", bus_adr, 0);
        @(negedge clk);
        chk("single_idle", bus_gnt, 0);

        // hold limit: 20 request cycles, two forced tenures of 8
        req = 4'b0010;
        adr_in[15:8] = 8'd7;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("hold_gnt", bus_gnt, 1);
                chk("hold_owner", owner, 1);
                chk("hold_adr", bus_adr, 7);
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("hold_low", bus_gnt, 0);
                chk("hold_low_owner", owner, 1);
            end
        end
        req = '0;

        // address captured at grant and held
        req = 4'b1000;
        adr_in[31:24] = 8'd100;
        @(negedge clk);
        chk("stab_owner", owner, 3);
        chk("stab_adr0", bus_adr, 100);
        adr_in[31:24] = 8'd55;
        @(negedge clk);
        chk("stab_adr1", bus_adr, 100);
        @(negedge clk);
        chk("stab_adr2", bus_adr, 100);
        req = '0;
        @(negedge clk);
        chk("stab_rel_gnt", bus_gnt, 0);
        chk("stab_rel_adr", bus_adr, 0);

        // async reset mid-tenure
        req = 4'b1000;
        @(negedge clk);
        chk("ar_idle", bus_gnt, 0);
        @(negedge clk);
        chk("ar_pre_gnt", gnt, 4'b1000);
        chk("ar_pre_adr", bus_adr, 55);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt", gnt, 0);
        chk("ar_busgnt", bus_gnt, 0);
        chk("ar_adr", bus_adr, 0);
        chk("ar_owner", owner, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_post_gnt", gnt, 4'b1000);
        chk("ar_post_owner", owner, 3);
        chk("ar_post_adr", bus_adr, 55);
        req = '0;
        @(negedge clk);
        chk("ar_gap", bus_gnt, 0);
        @(negedge clk);
        chk("ar_idle2", bus_gnt, 0);

        // one-cycle pulse gives a one-cycle grant, no regrant
        req = 4'b0001;
        @(negedge clk);
        chk("pulse_gnt", gnt, 4'b0001);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pulse_low", bus_gnt, 0);
        end

        // round robin across all four with MAX_HOLD=2
        req2 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                chk("rr_gnt", gnt2, exp_g[k]);
                chk("rr_adr", bus_adr2, exp_a[k]);
            end
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                chk("rr_gap", bus_gnt2, 0);
            end
        end
        req2 = '0;
        repeat (3) @(negedge clk);
        chk("rr_end", bus_gnt2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
